// File: rtl/ide_pkg.sv
// ide_pkg: shared types and constants for the IDE card's AutoConfig responder.
//   - ac_state_e   : configuration state (UNCONF / CONF / SHUTUP)
//   - CFG_BASE     : A23..A16 of the Zorro II config space ($E8xxxx)
//   - REG_*        : register indices (ADDR[6:1]) of the writable config registers
//   - ER_TYPE_*    : er_Type byte with and without the ROM-vector-valid bit
package ide_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    CONF   = 2'd1,
    SHUTUP = 2'd2
  } ac_state_e;

  localparam logic [7:0] CFG_BASE    = 8'hE8;

  // ADDR[6:1] indices: $48 -> 6'h24, $4A -> 6'h25, $4C -> 6'h26.
  localparam logic [5:0] REG_BASE_HI = 6'h24;
  localparam logic [5:0] REG_BASE_LO = 6'h25;
  localparam logic [5:0] REG_SHUTUP  = 6'h26;

  // Zorro II, 64 KB, no memory-list entry; bit 4 flags a valid diag ROM vector.
  localparam logic [7:0] ER_TYPE_PLAIN  = 8'hC1;
  localparam logic [7:0] ER_TYPE_ROMVEC = 8'hD1;

  // er_Flags: no special flags requested.
  localparam logic [7:0] ER_FLAGS = 8'h00;

endpackage

// File: rtl/ide_autoconfig_if.sv
// ide_autoconfig_if: 68000-side bus signals seen by the AutoConfig responder.
//   ADDR[23:1]  address A23..A1          AS_n   address strobe
//   UDS_n/LDS_n data strobes             RW     1 = read
//   DIN         write data D15..D12      DOUT   config nibble for D15..D12
//   DOE         drive enable for DOUT    DTACK  acknowledge for config cycles
// master: the CPU/bus side; slave: the responder.
interface ide_autoconfig_if;

  logic [23:1] ADDR;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;
  logic [3:0]  DIN;
  logic [3:0]  DOUT;
  logic        DOE;
  logic        DTACK;

  modport master (
    output ADDR, AS_n, UDS_n, LDS_n, RW, DIN,
    input  DOUT, DOE, DTACK
  );

  modport slave (
    input  ADDR, AS_n, UDS_n, LDS_n, RW, DIN,
    output DOUT, DOE, DTACK
  );

endinterface

// File: rtl/ide_autoconfig_rom.sv
// autoconfig_rom: combinational config-space lookup, register index -> nibble.
//   idx    in  6  register index (ADDR[6:1])
//   nibble out 4  value for D15..D12
// er_Type is returned as-is; every other field is returned inverted, as the
// AutoConfig protocol requires. Unmapped offsets read 4'hF.
// Optional macro ROMVEC_EN: reports er_Type $D1 and serves ~DIAG_VEC at
// $28..$2E; without it er_Type is $C1 and $28..$2E read 4'hF.
module autoconfig_rom
  import ide_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic [5:0] idx,
  output logic [3:0] nibble
);

`ifdef ROMVEC_EN
  localparam logic [7:0]  ER_TYPE = ER_TYPE_ROMVEC;
  localparam logic [15:0] DIAG_N  = ~DIAG_VEC;
`else
  localparam logic [7:0]  ER_TYPE = ER_TYPE_PLAIN;
  localparam logic [15:0] DIAG_N  = 16'hFFFF;
  logic [15:0] unused_diag;
  assign unused_diag = DIAG_VEC;
`endif

  localparam logic [7:0]  PROD_N   = ~PROD_ID;
  localparam logic [7:0]  FLAGS_N  = ~ER_FLAGS;
  localparam logic [15:0] MANUF_N  = ~MANUF_ID;
  localparam logic [31:0] SERIAL_N = ~SERIAL;

  // NOTE: the default assignment first means every path writes nibble, so no latch is inferred.
  always_comb begin
    nibble = 4'hF;
    case (idx)
      6'h00: nibble = ER_TYPE[7:4];
      6'h01: nibble = ER_TYPE[3:0];
      6'h02: nibble = PROD_N[7:4];
      6'h03: nibble = PROD_N[3:0];
      6'h04: nibble = FLAGS_N[7:4];
      6'h05: nibble = FLAGS_N[3:0];
      6'h08: nibble = MANUF_N[15:12];
      6'h09: nibble = MANUF_N[11:8];
      6'h0A: nibble = MANUF_N[7:4];
      6'h0B: nibble = MANUF_N[3:0];
      6'h0C: nibble = SERIAL_N[31:28];
      6'h0D: nibble = SERIAL_N[27:24];
      6'h0E: nibble = SERIAL_N[23:20];
      6'h0F: nibble = SERIAL_N[19:16];
      6'h10: nibble = SERIAL_N[15:12];
      6'h11: nibble = SERIAL_N[11:8];
      6'h12: nibble = SERIAL_N[7:4];
      6'h13: nibble = SERIAL_N[3:0];
      6'h14: nibble = DIAG_N[15:12];
      6'h15: nibble = DIAG_N[11:8];
      6'h16: nibble = DIAG_N[7:4];
      6'h17: nibble = DIAG_N[3:0];
      default: nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/ide_autoconfig.sv
// ide_autoconfig: Zorro II AutoConfig responder for the 64 KB IDE card.
// Answers nibble reads at $E8xxxx, accepts the base-address ($48/$4A) and
// shut-up ($4C) writes, then qualifies accesses to the assigned window.
//   CLK        in   board clock (E-clock domain, shared with the IDE block)
//   RESET      in   synchronous, active-high reset
//   bus        if   ide_autoconfig_if.slave (ADDR, strobes, RW, DIN/DOUT, DOE, DTACK)
//   CFGIN_n    in   daisy-chain input (low = this board may configure)
//   CFGOUT_n   out  daisy-chain output (low once configured or shut up)
//   ide_access out  access to the assigned 64 KB window
// Optional macro ROMVEC_EN: see autoconfig_rom (er_Type $D1, diag vector).
module ide_autoconfig
  import ide_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic              CLK,
  input  logic              RESET,
  ide_autoconfig_if.slave   bus,
  input  logic              CFGIN_n,
  output logic              CFGOUT_n,
  output logic              ide_access
);

  ac_state_e   state_q, state_d;
  logic [7:0]  base_q, base_d;
  logic [1:0]  as_s;
  logic [1:0]  ds_s;
  logic        dtack_q;
  logic        wr_done_q;
  logic        ds;
  logic        cfg_sel;
  logic        wr_commit;
  logic [5:0]  reg_idx;
  logic [3:0]  rom_nib;

  assign ds      = !bus.UDS_n || !bus.LDS_n;
  assign reg_idx = bus.ADDR[6:1];

  // Config space only decodes while this board is the unconfigured one in the chain.
  assign cfg_sel = (bus.ADDR[23:16] == CFG_BASE) && !bus.AS_n && !CFGIN_n
                   && (state_q == UNCONF);

  // One commit per bus cycle: wr_done_q holds off repeats until AS_n is seen high.
  assign wr_commit = !bus.RW && cfg_sel && ds_s[0] && !wr_done_q;

  autoconfig_rom #(
    .MANUF_ID (MANUF_ID),
    .PROD_ID  (PROD_ID),
    .SERIAL   (SERIAL),
    .DIAG_VEC (DIAG_VEC)
  ) u_rom (
    .idx    (reg_idx),
    .nibble (rom_nib)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    if (wr_commit) begin
      case (reg_idx)
        REG_BASE_LO: base_d[3:0] = bus.DIN;
        REG_BASE_HI: begin
          base_d[7:4] = bus.DIN;
          state_d     = CONF;
        end
        REG_SHUTUP:  state_d = SHUTUP;
        default:     ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= UNCONF;
      base_q    <= 8'h00;
      as_s      <= 2'b11;
      ds_s      <= 2'b00;
      dtack_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      as_s    <= {as_s[0], bus.AS_n};
      ds_s    <= {ds_s[0], ds};

      // Release uses raw AS_n so DTACK drops on the first edge after the cycle ends.
      if (bus.AS_n)
        dtack_q <= 1'b0;
      else if (cfg_sel && !as_s[0])
        dtack_q <= 1'b1;

      if (wr_commit)
        wr_done_q <= 1'b1;
      else if (as_s[0])
        wr_done_q <= 1'b0;
    end
  end

  assign bus.DOE   = cfg_sel && bus.RW;
  assign bus.DOUT  = bus.DOE ? rom_nib : 4'hF;
  assign bus.DTACK = dtack_q;

  assign CFGOUT_n   = (state_q == UNCONF);
  assign ide_access = (state_q == CONF) && !bus.AS_n && (bus.ADDR[23:16] == base_q);

  // Address bits between the window select and the register index, and the
  // second synchroniser stages, have no consumer here.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.ADDR[15:7], as_s[1], ds_s[1]};

endmodule

// File: tb/tb_ide_autoconfig.sv
// tb_ide_autoconfig: directed, scoreboard-checked bench for ide_autoconfig.
// Expected values are queued as each bus cycle is launched and popped as the
// DUT's response is sampled (#1 after a rising edge, or on a falling edge).
module tb_ide_autoconfig;

  logic CLK = 1'b0;
  logic RESET;
  logic CFGIN_n;
  logic CFGOUT_n;
  logic ide_access;

  ide_autoconfig_if bus ();

  ide_autoconfig #(
    .MANUF_ID (16'h07DB),
    .PROD_ID  (8'h05),
    .SERIAL   (32'h00000001),
    .DIAG_VEC (16'h0080)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus),
    .CFGIN_n    (CFGIN_n),
    .CFGOUT_n   (CFGOUT_n),
    .ide_access (ide_access)
  );

  always #5 CLK = ~CLK;

`ifdef ROMVEC_EN
  localparam logic [7:0] ER_HI   = 8'h0D;
  localparam logic [7:0] DIAG_2C = 8'h07;
`else
  localparam logic [7:0] ER_HI   = 8'h0C;
  localparam logic [7:0] DIAG_2C = 8'h0F;
`endif

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic expect_val(input string tag, input logic [7:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required <queued value>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic bus_idle();
    bus.AS_n  = 1'b1;
    bus.UDS_n = 1'b1;
    bus.LDS_n = 1'b1;
    bus.RW    = 1'b1;
  endtask

  task automatic start_cycle(input logic [23:0] a, input logic rw, input logic [3:0] d);
    @(negedge CLK);
    bus.ADDR  = a[23:1];
    bus.RW    = rw;
    bus.DIN   = d;
    bus.AS_n  = 1'b0;
    bus.UDS_n = 1'b0;
    bus.LDS_n = 1'b1;
  endtask

  // Negate strobes and give the synchronisers time to see the idle bus.
  task automatic end_cycle();
    @(negedge CLK);
    bus_idle();
    repeat (2) @(posedge CLK);
  endtask

  // Bounded wait: DTACK must appear within 2 rising edges of AS_n going low.
  task automatic wait_dtack(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (bus.DTACK) seen = 1'b1;
    end
  endtask

  task automatic cfg_read(input string tag, input logic [23:0] a,
                          input logic [7:0] exp_nib, input logic [7:0] exp_ack);
    logic seen;
    expect_val({tag, "_dtack"}, exp_ack);
    expect_val({tag, "_doe"}, exp_ack);
    if (exp_ack != 8'h00) expect_val({tag, "_dout"}, exp_nib);
    start_cycle(a, 1'b1, 4'h0);
    wait_dtack(seen);
    check(8'(seen));
    check(8'(bus.DOE));
    if (exp_ack != 8'h00) check(8'(bus.DOUT));
    end_cycle();
  endtask

  task automatic cfg_write(input string tag, input logic [23:0] a,
                           input logic [3:0] d, input logic [7:0] exp_ack);
    logic seen;
    expect_val({tag, "_dtack"}, exp_ack);
    start_cycle(a, 1'b0, d);
    wait_dtack(seen);
    check(8'(seen));
    end_cycle();
  endtask

  task automatic ide_probe(input string tag, input logic [23:0] a, input logic [7:0] exp_acc);
    logic seen;
    expect_val({tag, "_ide_access"}, exp_acc);
    expect_val({tag, "_dtack"}, 8'h00);
    start_cycle(a, 1'b1, 4'h0);
    #1;
    check(8'(ide_access));
    wait_dtack(seen);
    check(8'(seen));
    end_cycle();
  endtask

  task automatic pulse_reset(input int n);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (n) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    logic seen;
    bus_idle();
    bus.ADDR = '0;
    bus.DIN  = 4'h0;
    CFGIN_n  = 1'b0;
    RESET    = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state, bus idle.
    expect_val("rst_dtack", 8'h00);     check(8'(bus.DTACK));
    expect_val("rst_doe", 8'h00);       check(8'(bus.DOE));
    expect_val("rst_dout", 8'h0F);      check(8'(bus.DOUT));
    expect_val("rst_cfgout", 8'h01);    check(8'(CFGOUT_n));
    expect_val("rst_ide", 8'h00);       check(8'(ide_access));

    // Config-space reads.
    cfg_read("ertype_hi", 24'hE80000, ER_HI, 8'h01);
    cfg_read("ertype_lo", 24'hE80002, 8'h01, 8'h01);
    cfg_read("prod_hi",   24'hE80004, 8'h0F, 8'h01);
    cfg_read("prod_lo",   24'hE80006, 8'h0A, 8'h01);
    cfg_read("flags_hi",  24'hE80008, 8'h0F, 8'h01);
    cfg_read("manuf_0",   24'hE80010, 8'h0F, 8'h01);
    cfg_read("manuf_1",   24'hE80012, 8'h08, 8'h01);
    cfg_read("manuf_2",   24'hE80014, 8'h02, 8'h01);
    cfg_read("manuf_3",   24'hE80016, 8'h04, 8'h01);
    cfg_read("serial_ms", 24'hE80018, 8'h0F, 8'h01);
    cfg_read("serial_ls", 24'hE80026, 8'h0E, 8'h01);
    cfg_read("diag_2c",   24'hE8002C, DIAG_2C, 8'h01);
    cfg_read("unmapped",  24'hE80030, 8'h0F, 8'h01);
    cfg_read("reg_4a_rd", 24'hE8004A, 8'h0F, 8'h01);

    // Chain input high: no response, writes ignored.
    CFGIN_n = 1'b1;
    cfg_read("cfgin_hi_rd", 24'hE80000, 8'h00, 8'h00);
    cfg_write("cfgin_hi_wr", 24'hE8004C, 4'h0, 8'h00);
    CFGIN_n = 1'b0;
    expect_val("cfgin_hi_cfgout", 8'h01);  check(8'(CFGOUT_n));

    // AS_n negates before a data strobe is seen: no commit.
    @(negedge CLK);
    bus.ADDR = 23'(24'hE8004C >> 1);
    bus.RW   = 1'b0;
    bus.AS_n = 1'b0;
    @(negedge CLK);
    bus.AS_n = 1'b1;
    @(negedge CLK);
    bus.UDS_n = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    bus_idle();
    repeat (2) @(posedge CLK);
    #1;
    expect_val("abort_cfgout", 8'h01);  check(8'(CFGOUT_n));

    // Reset in the middle of an acknowledged cycle drops DTACK on that edge.
    expect_val("midrst_dtack_pre", 8'h01);
    expect_val("midrst_dtack_post", 8'h00);
    start_cycle(24'hE80002, 1'b1, 4'h0);
    wait_dtack(seen);
    check(8'(seen));
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check(8'(bus.DTACK));
    @(negedge CLK);
    RESET = 1'b0;
    end_cycle();

    // Configure at base $EE.
    cfg_write("base_lo", 24'hE8004A, 4'hE, 8'h01);
    expect_val("cfgout_after_lo", 8'h01);  check(8'(CFGOUT_n));
    cfg_write("base_hi", 24'hE80048, 4'hE, 8'h01);
    expect_val("cfgout_conf", 8'h00);      check(8'(CFGOUT_n));
    ide_probe("ide_hit",  24'hEE1000, 8'h01);
    ide_probe("ide_miss", 24'hEF0000, 8'h00);
    cfg_read("conf_e8_rd", 24'hE80000, 8'h00, 8'h00);

    // One-clock reset returns to UNCONF.
    pulse_reset(1);
    expect_val("rst2_cfgout", 8'h01);  check(8'(CFGOUT_n));
    ide_probe("rst2_ide", 24'hEE1000, 8'h00);
    cfg_read("rst2_reread", 24'hE80000, ER_HI, 8'h01);

    // Shut-up: terminal, no window, no config response.
    cfg_write("shutup", 24'hE8004C, 4'h0, 8'h01);
    expect_val("shut_cfgout", 8'h00);  check(8'(CFGOUT_n));
    ide_probe("shut_ide_base0", 24'h000000, 8'h00);
    ide_probe("shut_ide_ee",    24'hEE1000, 8'h00);
    cfg_read("shut_rd", 24'hE80000, 8'h00, 8'h00);

    // Base $E8 is legal; once configured the window decodes as IDE.
    pulse_reset(1);
    cfg_write("e8_lo", 24'hE8004A, 4'h8, 8'h01);
    cfg_write("e8_hi", 24'hE80048, 4'hE, 8'h01);
    ide_probe("e8_ide", 24'hE80000, 8'h01);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
